// File: rtl/key_pulse_array.sv
// N-channel key conditioner: 2-FF synchroniser, counter debounce, one-cycle press/release
// pulses and optional hold-to-repeat. The release pulse port is release_pulse because release is reserved.
module key_pulse_array #(
  parameter int N_KEYS        = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DEBOUNCE_CYC  = 16,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] held
);

  localparam int DCW  = $clog2(DEBOUNCE_CYC + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rstate_t;

  logic [N_KEYS-1:0] k_s;

  assign k_s = (ACTIVE_LOW != 0) ? ~key_in : key_in;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    logic           sync1_r;
    logic           sync2_r;
    logic           held_r;
    logic           press_r;
    logic           release_r;
    logic [DCW-1:0] dc_r;
    logic [RCW-1:0] rc_r;
    rstate_t        st_r;
    logic           toggle_s;

    // The debounced level flips on the same edge the D-th differing sample is taken.
    assign toggle_s = (sync2_r != held_r) && (dc_r == DCW'(DEBOUNCE_CYC - 1));

    // Per-channel synchroniser, debounce counter, repeat FSM and registered pulses.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_r   <= 1'b0;
        sync2_r   <= 1'b0;
        held_r    <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        dc_r      <= '0;
        rc_r      <= '0;
        st_r      <= IDLE;
      end else begin
        sync1_r   <= k_s[gi];
        sync2_r   <= sync1_r;
        press_r   <= 1'b0;
        release_r <= 1'b0;

        if (sync2_r != held_r) begin
          if (toggle_s) begin
            held_r <= ~held_r;
            dc_r   <= '0;
          end else begin
            dc_r <= dc_r + DCW'(1);
          end
        end else begin
          dc_r <= '0;
        end

        if (toggle_s && !held_r) begin
          press_r <= 1'b1;
          rc_r    <= '0;
          st_r    <= HOLD;
        end else if (toggle_s && held_r) begin
          release_r <= 1'b1;
          rc_r      <= '0;
          st_r      <= IDLE;
        end else begin
          case (st_r)
            HOLD: begin
              if (REPEAT_EN != 0) begin
                if (rc_r == RCW'(REPEAT_DELAY - 1)) begin
                  press_r <= 1'b1;
                  rc_r    <= '0;
                  st_r    <= REPEAT;
                end else begin
                  rc_r <= rc_r + RCW'(1);
                end
              end else begin
                rc_r <= '0;
              end
            end
            REPEAT: begin
              if (rc_r == RCW'(REPEAT_PERIOD - 1)) begin
                press_r <= 1'b1;
                rc_r    <= '0;
              end else begin
                rc_r <= rc_r + RCW'(1);
              end
            end
            default: begin
              rc_r <= '0;
            end
          endcase
        end
      end
    end

    assign press[gi]         = press_r;
    assign release_pulse[gi] = release_r;
    assign held[gi]          = held_r;
  end

endmodule

// File: tb/tb_key_pulse_array.sv
// Scoreboard bench for key_pulse_array: one instance without repeat, one with repeat.
module tb_key_pulse_array;

  typedef struct {
    int         cyc;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] h;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] key0, key1;
  logic [1:0] press0, rel0, held0;
  logic [1:0] press1, rel1, held1;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  ev_t        q0[$];
  ev_t        q1[$];

  key_pulse_array #(.N_KEYS(2), .ACTIVE_LOW(1), .DEBOUNCE_CYC(4), .REPEAT_EN(0),
                    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut0 (
    .clk(clk), .reset(reset), .key_in(key0),
    .press(press0), .release_pulse(rel0), .held(held0));

  key_pulse_array #(.N_KEYS(2), .ACTIVE_LOW(1), .DEBOUNCE_CYC(4), .REPEAT_EN(1),
                    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut1 (
    .clk(clk), .reset(reset), .key_in(key1),
    .press(press1), .release_pulse(rel1), .held(held1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push0(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] h);
    ev_t e;
    e.cyc = c; e.p = p; e.r = r; e.h = h;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] h);
    ev_t e;
    e.cyc = c; e.p = p; e.r = r; e.h = h;
    q1.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse on either instance must match the next scoreboard entry.
  always @(negedge clk) begin
    ev_t e;
    if ((press0 | rel0) != 2'b00) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut0_unexpected_pulse actual=p%b/r%b required=none (cyc %0d)", press0, rel0, cyc);
      end else begin
        e = q0.pop_front();
        chk("dut0_cyc", cyc, e.cyc);
        chk("dut0_press", {30'd0, press0}, {30'd0, e.p});
        chk("dut0_release", {30'd0, rel0}, {30'd0, e.r});
        chk("dut0_held", {30'd0, held0}, {30'd0, e.h});
      end
    end
    if ((press1 | rel1) != 2'b00) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_unexpected_pulse actual=p%b/r%b required=none (cyc %0d)", press1, rel1, cyc);
      end else begin
        e = q1.pop_front();
        chk("dut1_cyc", cyc, e.cyc);
        chk("dut1_press", {30'd0, press1}, {30'd0, e.p});
        chk("dut1_release", {30'd0, rel1}, {30'd0, e.r});
        chk("dut1_held", {30'd0, held1}, {30'd0, e.h});
      end
    end
  end

  initial begin
    int c;
    int t;
    reset = 1'b1;
    key0  = 2'b11;
    key1  = 2'b11;

    // Reset for three cycles with keys released.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outs0", {26'd0, press0, rel0, held0}, 32'd0);
      chk("reset_outs1", {26'd0, press1, rel1, held1}, 32'd0);
    end
    reset = 1'b0;
    wait_cyc(10);
    chk("idle_held0", {30'd0, held0}, 32'd0);

    // Single press without repeat, long hold, then release.
    c = cyc;
    key0[0] = 1'b0;
    push0(c + 6, 2'b01, 2'b00, 2'b01);
    wait_cyc(5);
    chk("pre_latency_held0", {30'd0, held0}, 32'd0);
    wait_cyc(15);
    chk("hold_held0", {30'd0, held0}, 32'd1);
    wait_cyc(25);
    c = cyc;
    key0[0] = 1'b1;
    push0(c + 6, 2'b00, 2'b01, 2'b00);
    wait_cyc(12);

    // Glitch of three samples is rejected.
    key0[0] = 1'b0;
    wait_cyc(3);
    key0[0] = 1'b1;
    wait_cyc(12);
    chk("glitch_held0", {30'd0, held0}, 32'd0);

    // Hold-to-repeat on channel 1 of the repeating instance.
    c = cyc;
    key1[1] = 1'b0;
    push1(c + 6, 2'b10, 2'b00, 2'b10);
    t = 10;
    while (t < 30) begin
      push1(c + 6 + t, 2'b10, 2'b00, 2'b10);
      t = t + 3;
    end
    wait_cyc(30);
    key1[1] = 1'b1;
    push1(c + 36, 2'b00, 2'b10, 2'b00);
    wait_cyc(14);
    chk("repeat_done_held1", {30'd0, held1}, 32'd0);

    // Simultaneous press and release on both channels.
    c = cyc;
    key0 = 2'b00;
    push0(c + 6, 2'b11, 2'b00, 2'b11);
    wait_cyc(15);
    c = cyc;
    key0 = 2'b11;
    push0(c + 6, 2'b00, 2'b11, 2'b00);
    wait_cyc(12);

    // Reset while held: outputs clear with no release, then re-press after latency.
    c = cyc;
    key0[0] = 1'b0;
    push0(c + 6, 2'b01, 2'b00, 2'b01);
    wait_cyc(10);
    chk("before_reset_held0", {30'd0, held0}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outs0", {26'd0, press0, rel0, held0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    c = cyc;
    push0(c + 6, 2'b01, 2'b00, 2'b01);
    wait_cyc(12);
    chk("after_reset_held0", {30'd0, held0}, 32'd1);
    c = cyc;
    key0[0] = 1'b1;
    push0(c + 6, 2'b00, 2'b01, 2'b00);
    wait_cyc(12);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
